// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit bus CPU control path:
//   - opcode constants (IR upper nibble)
//   - T-state encodings (T1..T5, HALT)
//   - control-word bit indices used by the sequencer, the register blocks
//     and the bench
// Optional feature macro: CTRL_JMP_EN (JMP/JZ opcodes are decoded only
// when it is defined; the constants are always present).
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Sequencer steps; codes 5 and 6 are unused and recover to T1.
  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    HALT = 3'd7
  } tstate_e;

  // Control-word bit indices
  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_PC_IN   = 2;
  localparam int CW_MAR_IN  = 3;
  localparam int CW_RAM_OUT = 4;
  localparam int CW_IR_IN   = 5;
  localparam int CW_IR_OUT  = 6;
  localparam int CW_A_IN    = 7;
  localparam int CW_A_OUT   = 8;
  localparam int CW_B_IN    = 9;
  localparam int CW_ALU_OUT = 10;
  localparam int CW_ALU_SUB = 11;
  localparam int CW_OUT_IN  = 12;
  localparam int CW_W       = 13;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // One-hot control word with only bit idx set.
  function automatic ctrl_word_t cw_bit(input int idx);
    return ctrl_word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational microcode: maps the current step, opcode and zero
// flag to the control word for this step and the next step value.
// Optional feature macro: CTRL_JMP_EN (adds JMP 0011 and JZ 0100; without
// it those opcodes are NOPs and zero_flag_i is ignored).
// Ports:
//   state_i       current T-state (registered in the top)
//   opc_i         opcode from the IR upper nibble
//   zero_flag_i   ALU zero result (JZ only)
//   cw_o          ungated control word for this step
//   next_state_o  step to enter on the next enabled edge
// ---------------------------------------------------------------------------
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  tstate_e          state_i,
  input  logic [OPC_W-1:0] opc_i,
  input  logic             zero_flag_i,
  output ctrl_word_t       cw_o,
  output tstate_e          next_state_o
);

  logic [3:0] opc;
  assign opc = 4'(opc_i);

`ifndef CTRL_JMP_EN
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag_i;
`endif

  always_comb begin
    cw_o         = '0;
    next_state_o = T1;
    case (state_i)
      T1: begin
        cw_o         = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
        next_state_o = T2;
      end
      T2: begin
        cw_o         = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_INC);
        next_state_o = T3;
      end
      T3: begin
        case (opc)
          OP_LDA, OP_ADD, OP_SUB: begin
            // Operand address from the IR low nibble into the MAR.
            cw_o         = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
            next_state_o = T4;
          end
          OP_OUT: cw_o = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
          OP_HLT: next_state_o = HALT;
`ifdef CTRL_JMP_EN
          OP_JMP: cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_IN);
          OP_JZ: begin
            if (zero_flag_i) begin
              cw_o = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_IN);
            end
          end
`endif
          default: ;  // NOP: no strobes, back to T1
        endcase
      end
      T4: begin
        case (opc)
          OP_LDA: cw_o = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
          OP_ADD: begin
            cw_o         = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
            next_state_o = T5;
          end
          OP_SUB: begin
            // alu_sub is raised one step early so the ALU output has
            // settled to A-B by the time T5 puts it on the bus.
            cw_o         = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN) | cw_bit(CW_ALU_SUB);
            next_state_o = T5;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opc)
          OP_ADD: cw_o = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN);
          OP_SUB: cw_o = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_ALU_SUB);
          default: ;
        endcase
      end
      HALT: next_state_o = HALT;  // absorbing, strobes stay 0
      default: ;                  // unused codes recover to T1
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq
// Control sequencer for the 8-bit bus CPU. Holds the T-state register and
// halt latch, and gates the decoded control word with reset/enable.
// Optional feature macro: CTRL_JMP_EN (JMP/JZ support; pc_in tied to 0
// when undefined).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              step enable; 0 freezes the step and zeroes strobes
//   ir_opc          opcode from the IR (valid from T3)
//   zero_flag       ALU zero flag (JZ)
//   pc_inc/pc_out/pc_in, mar_in, ram_out, ir_in, ir_out, a_in, a_out,
//   b_in, alu_out, alu_sub, out_in   register load / bus-drive strobes
//   halted          high after HLT until reset
//   t_state         current step: T1=0 .. T5=4, HALT=7
// ---------------------------------------------------------------------------
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPC_W-1:0] ir_opc,
  input  logic             zero_flag,
  output logic             pc_inc,
  output logic             pc_out,
  output logic             pc_in,
  output logic             mar_in,
  output logic             ram_out,
  output logic             ir_in,
  output logic             ir_out,
  output logic             a_in,
  output logic             a_out,
  output logic             b_in,
  output logic             alu_out,
  output logic             alu_sub,
  output logic             out_in,
  output logic             halted,
  output logic [2:0]       t_state
);

  tstate_e    state_q, state_d, next_state;
  logic       halted_q, halted_d;
  ctrl_word_t cw_raw, cw_gated;
  logic       step_en;

  ctrl_decode #(
    .OPC_W(OPC_W)
  ) u_decode (
    .state_i      (state_q),
    .opc_i        (ir_opc),
    .zero_flag_i  (zero_flag),
    .cw_o         (cw_raw),
    .next_state_o (next_state)
  );

  // Reset dominates enable; both silence every strobe in the same cycle.
  assign step_en = en & ~rst;

  for (genvar gi = 0; gi < CW_W; gi++) begin : g_gate
    assign cw_gated[gi] = cw_raw[gi] & step_en;
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (en) begin
      state_d  = next_state;
      halted_d = (next_state == HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign pc_inc  = cw_gated[CW_PC_INC];
  assign pc_out  = cw_gated[CW_PC_OUT];
  assign mar_in  = cw_gated[CW_MAR_IN];
  assign ram_out = cw_gated[CW_RAM_OUT];
  assign ir_in   = cw_gated[CW_IR_IN];
  assign ir_out  = cw_gated[CW_IR_OUT];
  assign a_in    = cw_gated[CW_A_IN];
  assign a_out   = cw_gated[CW_A_OUT];
  assign b_in    = cw_gated[CW_B_IN];
  assign alu_out = cw_gated[CW_ALU_OUT];
  assign alu_sub = cw_gated[CW_ALU_SUB];
  assign out_in  = cw_gated[CW_OUT_IN];

`ifdef CTRL_JMP_EN
  assign pc_in = cw_gated[CW_PC_IN];
`else
  logic unused_pc_in;
  assign unused_pc_in = cw_gated[CW_PC_IN];
  assign pc_in        = 1'b0;
`endif

  assign halted  = halted_q;
  assign t_state = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq
// Directed bench for ctrl_seq. A small bus/register model (PC, MAR, IR,
// A, B, OUT, 16-byte RAM) consumes the strobes so programs really execute.
// Optional feature macro: CTRL_JMP_EN (selects the JMP/JZ or NOP scenario).
// ---------------------------------------------------------------------------
module tb_ctrl_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, zero_flag;
  logic [3:0] ir_opc;
  logic       pc_inc, pc_out, pc_in, mar_in, ram_out, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, out_in, halted;
  logic [2:0] t_state;

  always #5 clk = ~clk;

  ctrl_seq #(.OPC_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ir_opc(ir_opc), .zero_flag(zero_flag),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in),
    .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in),
    .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub),
    .out_in(out_in), .halted(halted), .t_state(t_state)
  );

  // Expected strobe masks, hand-composed per step.
  localparam logic [12:0] S_PC_INC  = 13'h0001;
  localparam logic [12:0] S_PC_OUT  = 13'h0002;
  localparam logic [12:0] S_PC_IN   = 13'h0004;
  localparam logic [12:0] S_MAR_IN  = 13'h0008;
  localparam logic [12:0] S_RAM_OUT = 13'h0010;
  localparam logic [12:0] S_IR_IN   = 13'h0020;
  localparam logic [12:0] S_IR_OUT  = 13'h0040;
  localparam logic [12:0] S_A_IN    = 13'h0080;
  localparam logic [12:0] S_A_OUT   = 13'h0100;
  localparam logic [12:0] S_B_IN    = 13'h0200;
  localparam logic [12:0] S_ALU_OUT = 13'h0400;
  localparam logic [12:0] S_ALU_SUB = 13'h0800;
  localparam logic [12:0] S_OUT_IN  = 13'h1000;
  localparam logic [12:0] F1 = S_PC_OUT | S_MAR_IN;
  localparam logic [12:0] F2 = S_RAM_OUT | S_IR_IN | S_PC_INC;
  localparam logic [12:0] OPND = S_IR_OUT | S_MAR_IN;
  localparam logic [12:0] JUMP = S_IR_OUT | S_PC_IN;

  logic [12:0] obs;
  assign obs = {out_in, alu_sub, alu_out, b_in, a_out, a_in, ir_out,
                ir_in, ram_out, mar_in, pc_in, pc_out, pc_inc};

  // ---- datapath model ----
  logic [3:0] pc_m, mar_m;
  logic [7:0] ir_m, a_m, b_m, out_m, bus_m;
  logic [7:0] ram_m [16];

  assign ir_opc = ir_m[7:4];

  always_comb begin
    bus_m = 8'h00;
    if (pc_out)       bus_m = {4'h0, pc_m};
    else if (ram_out) bus_m = ram_m[mar_m];
    else if (ir_out)  bus_m = {4'h0, ir_m[3:0]};
    else if (a_out)   bus_m = a_m;
    else if (alu_out) bus_m = alu_sub ? (a_m - b_m) : (a_m + b_m);
  end

  always @(posedge clk) begin
    if (rst) begin
      pc_m <= 4'h0;
      ir_m <= 8'h00;
    end else begin
      if (pc_inc) pc_m  <= pc_m + 4'h1;
      if (pc_in)  pc_m  <= bus_m[3:0];
      if (mar_in) mar_m <= bus_m[3:0];
      if (ir_in)  ir_m  <= bus_m;
      if (a_in)   a_m   <= bus_m;
      if (b_in)   b_m   <= bus_m;
      if (out_in) out_m <= bus_m;
    end
  end

  // ---- checking ----
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Checks one step (t_state, strobes, halted) then advances to the next.
  task automatic check_cycle(input string tag, input logic [2:0] exp_t, input logic [12:0] exp_cw);
    #1;
    $display("cycle %-10s t_state=%0d cw=0x%04h bus=0x%02h", tag, t_state, obs, bus_m);
    check({tag, "_t"}, 32'(t_state), 32'(exp_t));
    check({tag, "_cw"}, 32'(obs), 32'(exp_cw));
    check({tag, "_halted"}, 32'(halted), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
  endtask

  // Bus exclusivity on every cycle of the run.
  always @(negedge clk) begin
    #1;
    check("bus_excl", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; zero_flag = 1'b0;
    clear_ram();
    ram_m[0] = 8'h09;  // LDA 9
    ram_m[9] = 8'h2A;
    repeat (2) @(negedge clk);
    #1;
    $display("reset t_state=%0d halted=%0d cw=0x%04h", t_state, halted, obs);
    check("rst_t", 32'(t_state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cw", 32'(obs), 32'd0);
    rst = 1'b0;

    // LDA 9
    check_cycle("LDA_T1", 3'd0, F1);
    check_cycle("LDA_T2", 3'd1, F2);
    check_cycle("LDA_T3", 3'd2, OPND);
    check_cycle("LDA_T4", 3'd3, S_RAM_OUT | S_A_IN);
    check("lda_a", 32'(a_m), 32'h2A);

    // LDA 11 (=5), ADD 10 (=3), SUB 10, OUT, HLT
    clear_ram();
    ram_m[0] = 8'h0B; ram_m[1] = 8'h1A; ram_m[2] = 8'h2A;
    ram_m[3] = 8'hE0; ram_m[4] = 8'hF0;
    ram_m[10] = 8'h03; ram_m[11] = 8'h05;
    do_reset();
    check_cycle("LDA_T1", 3'd0, F1);
    check_cycle("LDA_T2", 3'd1, F2);
    check_cycle("LDA_T3", 3'd2, OPND);
    check_cycle("LDA_T4", 3'd3, S_RAM_OUT | S_A_IN);
    check("lda5_a", 32'(a_m), 32'h05);
    check_cycle("ADD_T1", 3'd0, F1);
    check_cycle("ADD_T2", 3'd1, F2);
    check_cycle("ADD_T3", 3'd2, OPND);
    check_cycle("ADD_T4", 3'd3, S_RAM_OUT | S_B_IN);
    check_cycle("ADD_T5", 3'd4, S_ALU_OUT | S_A_IN);
    check("add_a", 32'(a_m), 32'h08);
    check_cycle("SUB_T1", 3'd0, F1);
    check_cycle("SUB_T2", 3'd1, F2);
    check_cycle("SUB_T3", 3'd2, OPND);
    check_cycle("SUB_T4", 3'd3, S_RAM_OUT | S_B_IN | S_ALU_SUB);
    check_cycle("SUB_T5", 3'd4, S_ALU_OUT | S_A_IN | S_ALU_SUB);
    check("sub_a", 32'(a_m), 32'h05);
    check_cycle("OUT_T1", 3'd0, F1);
    check_cycle("OUT_T2", 3'd1, F2);
    check_cycle("OUT_T3", 3'd2, S_A_OUT | S_OUT_IN);
    check("out_reg", 32'(out_m), 32'h05);
    check_cycle("HLT_T1", 3'd0, F1);
    check_cycle("HLT_T2", 3'd1, F2);
    check_cycle("HLT_T3", 3'd2, 13'h0000);
    for (int i = 0; i < 20; i++) begin
      #1;
      $display("halt cycle %0d t_state=%0d halted=%0d cw=0x%04h", i, t_state, halted, obs);
      check("halt_t", 32'(t_state), 32'd7);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_cw", 32'(obs), 32'd0);
      @(negedge clk);
    end

    // rst pulsed at ADD T4 (A=5 from the SUB above)
    clear_ram();
    ram_m[0] = 8'h1A; ram_m[10] = 8'h03;
    do_reset();
    check_cycle("ADD_T1", 3'd0, F1);
    check_cycle("ADD_T2", 3'd1, F2);
    check_cycle("ADD_T3", 3'd2, OPND);
    rst = 1'b1;
    #1;
    $display("rst at ADD_T4 t_state=%0d cw=0x%04h", t_state, obs);
    check("rstmid_t", 32'(t_state), 32'd3);
    check("rstmid_cw", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_cycle("RST_T1", 3'd0, F1);
    check_cycle("RST_T2", 3'd1, F2);
    check_cycle("RST_T3", 3'd2, OPND);
    check_cycle("RST_T4", 3'd3, S_RAM_OUT | S_B_IN);
    check_cycle("RST_T5", 3'd4, S_ALU_OUT | S_A_IN);
    check("rst_add_a", 32'(a_m), 32'h08);

    // en low for 3 cycles at LDA T3
    clear_ram();
    ram_m[0] = 8'h09; ram_m[9] = 8'h2A;
    do_reset();
    check_cycle("LDA_T1", 3'd0, F1);
    check_cycle("LDA_T2", 3'd1, F2);
    en = 1'b0;
    check_cycle("EN0_1", 3'd2, 13'h0000);
    check_cycle("EN0_2", 3'd2, 13'h0000);
    check_cycle("EN0_3", 3'd2, 13'h0000);
    en = 1'b1;
    check_cycle("LDA_T3", 3'd2, OPND);
    check_cycle("LDA_T4", 3'd3, S_RAM_OUT | S_A_IN);
    check("en_a", 32'(a_m), 32'h2A);

    // rst together with en=0 from T2: reset wins
    check_cycle("LDA_T1", 3'd0, F1);
    en = 1'b0; rst = 1'b1;
    #1;
    check("rsten_cw", 32'(obs), 32'd0);
    @(negedge clk);
    #1;
    $display("rst+en0 t_state=%0d", t_state);
    check("rsten_t", 32'(t_state), 32'd0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);

    clear_ram();
`ifdef CTRL_JMP_EN
    ram_m[0] = 8'h47; ram_m[1] = 8'h47; ram_m[7] = 8'h3C; ram_m[12] = 8'h50;
    do_reset();
    zero_flag = 1'b0;
    check_cycle("JZ0_T1", 3'd0, F1);
    check_cycle("JZ0_T2", 3'd1, F2);
    check_cycle("JZ0_T3", 3'd2, 13'h0000);
    check("jz0_pc", 32'(pc_m), 32'd1);
    zero_flag = 1'b1;
    check_cycle("JZ1_T1", 3'd0, F1);
    check_cycle("JZ1_T2", 3'd1, F2);
    check_cycle("JZ1_T3", 3'd2, JUMP);
    check("jz1_pc", 32'(pc_m), 32'd7);
    check_cycle("JMP_T1", 3'd0, F1);
    check_cycle("JMP_T2", 3'd1, F2);
    check_cycle("JMP_T3", 3'd2, JUMP);
    check("jmp_pc", 32'(pc_m), 32'd12);
    check_cycle("NOP_T1", 3'd0, F1);
    check_cycle("NOP_T2", 3'd1, F2);
    check_cycle("NOP_T3", 3'd2, 13'h0000);
    check("nop_pc", 32'(pc_m), 32'd13);
`else
    ram_m[0] = 8'h47; ram_m[1] = 8'h3C; ram_m[2] = 8'h50;
    do_reset();
    zero_flag = 1'b1;
    check_cycle("JZN_T1", 3'd0, F1);
    check_cycle("JZN_T2", 3'd1, F2);
    check_cycle("JZN_T3", 3'd2, 13'h0000);
    check_cycle("JMPN_T1", 3'd0, F1);
    check_cycle("JMPN_T2", 3'd1, F2);
    check_cycle("JMPN_T3", 3'd2, 13'h0000);
    check_cycle("NOP_T1", 3'd0, F1);
    check_cycle("NOP_T2", 3'd1, F2);
    check_cycle("NOP_T3", 3'd2, 13'h0000);
    check("nop_pc", 32'(pc_m), 32'd3);
`endif
    check_cycle("NEXT_T1", 3'd0, F1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
